// File: rtl/flash_audio_pkg.sv
// rtl/flash_audio_pkg.sv - shared state type, constants and sample-select helper for the flash audio sequencer
package flash_audio_pkg;

  localparam int         SAMPLE_W         = 16;
  localparam logic [3:0] FLASH_BYTEENABLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PLAY0     = 3'd3,
    ST_PLAY1     = 3'd4,
    ST_STEP      = 3'd5
  } seq_state_e;

  // Forward playback emits the low half first; backward emits the high half first.
  function automatic logic [SAMPLE_W-1:0] pick_half(
    input logic [31:0] word,
    input logic        fwd,
    input logic        second
  );
    return (fwd ^ second) ? word[15:0] : word[31:16];
  endfunction

endpackage

// File: rtl/flash_addr_stepper.sv
// rtl/flash_addr_stepper.sv - flash word address register with range wrap, direction and restart load
module flash_addr_stepper
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              dir_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Limits are compared before moving, so the address never leaves the range.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = dir_i ? START_ADDR : END_ADDR;
    end else if (step_i) begin
      if (dir_i) begin
        addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= START_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/flash_audio_sequencer.sv
// rtl/flash_audio_sequencer.sv - reads 32-bit flash words and paces their 16-bit halves out as audio samples
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                play,
  input  logic                dir,
  input  logic                restart,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [31:0]         flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic                underrun,
  output logic                busy
);

  seq_state_e          state_q;
  logic                read_q;
  logic                busy_q;
  logic                audio_valid_q;
  logic                underrun_q;
  logic                restart_pending_q;
  logic                word_dir_q;
  logic [31:0]         word_q;
  logic [SAMPLE_W-1:0] audio_q;

  logic tick_play;
  logic in_idle;
  logic in_step;
  logic starved;
  logic restart_now;
  logic addr_load;
  logic addr_step;

  assign tick_play   = sample_tick & play;
  assign in_idle     = (state_q == ST_IDLE);
  assign in_step     = (state_q == ST_STEP);
  assign starved     = (state_q == ST_REQ) | (state_q == ST_WAIT_DATA) | in_step;
  assign restart_now = restart_pending_q | restart;

  // A restart in IDLE moves the address at once; elsewhere it waits for STEP.
  assign addr_load = (in_idle & restart) | (in_step & restart_now);
  assign addr_step = in_step & ~restart_now;

  flash_addr_stepper #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_stepper (
    .clk    (clk),
    .reset  (reset),
    .load_i (addr_load),
    .step_i (addr_step),
    .dir_i  (dir),
    .addr_o (flash_mem_address)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      read_q            <= 1'b0;
      busy_q            <= 1'b0;
      audio_valid_q     <= 1'b0;
      underrun_q        <= 1'b0;
      restart_pending_q <= 1'b0;
      word_dir_q        <= 1'b1;
      word_q            <= '0;
      audio_q           <= '0;
    end else begin
      audio_valid_q <= 1'b0;
      underrun_q    <= 1'b0;

      if (restart && !in_idle && !in_step) begin
        restart_pending_q <= 1'b1;
      end

      if (tick_play && starved) begin
        underrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (play) begin
            state_q <= ST_REQ;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        // The Avalon request is held until accepted, whatever play does.
        ST_REQ: begin
          if (!flash_mem_waitrequest) begin
            state_q <= ST_WAIT_DATA;
            read_q  <= 1'b0;
          end
        end

        ST_WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            state_q    <= ST_PLAY0;
            word_q     <= flash_mem_readdata;
            word_dir_q <= dir;
          end
        end

        ST_PLAY0, ST_PLAY1: begin
          if (tick_play) begin
            audio_q       <= pick_half(word_q, word_dir_q, state_q == ST_PLAY1);
            audio_valid_q <= 1'b1;
            state_q       <= (state_q == ST_PLAY0) ? ST_PLAY1 : ST_STEP;
          end
        end

        ST_STEP: begin
          restart_pending_q <= 1'b0;
          if (play) begin
            state_q <= ST_REQ;
            read_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_mem_read       = read_q;
  assign flash_mem_byteenable = FLASH_BYTEENABLE;
  assign audio_out            = audio_q;
  assign audio_valid          = audio_valid_q;
  assign underrun             = underrun_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb/tb_flash_audio_sequencer.sv - randomized self-checking bench for flash_audio_sequencer
module tb_flash_audio_sequencer;

  localparam int                ADDR_W  = 23;
  localparam logic [ADDR_W-1:0] START_A = 23'd0;
  localparam logic [ADDR_W-1:0] END_A   = 23'd7;

  logic              clk = 1'b0;
  logic              reset, sample_tick, play, dir, restart;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;
  logic [15:0]       audio_out;
  logic              audio_valid, underrun, busy;

  flash_audio_sequencer #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_A),
    .END_ADDR   (END_A)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .sample_tick             (sample_tick),
    .play                    (play),
    .dir                     (dir),
    .restart                 (restart),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_out               (audio_out),
    .audio_valid             (audio_valid),
    .underrun                (underrun),
    .busy                    (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash slave knobs and state
  int          wait_min = 0, wait_max = 0, lat_min = 0, lat_max = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_data = '0;
  bit          in_req = 0;
  int          wait_cnt = 0;
  bit          resp_pending = 0, resp_stray = 0, drv_stray = 0;
  int          lat_cnt = 0;
  logic [31:0] resp_data = '0;

  // Reference model: next read address, pending restart, samples still owed
  logic [ADDR_W-1:0] exp_addr = START_A;
  bit                rst_flag = 0;
  logic [15:0]       sq[$];
  int                word_samples = 0;
  logic [15:0]       last_audio = '0;
  logic [ADDR_W-1:0] acc_log[$];
  logic [15:0]       samp_log[$];
  int                under_cnt = 0;

  bit                p_reset = 1, p_tick = 0, p_play = 0, p_dir = 1, p_wr = 0, p_rvalid = 0, p_stray = 0;
  bit                o_read = 0, o_busy = 0;
  logic [ADDR_W-1:0] o_addr = '0;
  bit                drv_reset = 1, drv_play = 0, drv_dir = 1;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input bit fwd);
    int ai;
    ai = int'(a);
    if (fwd) ai = (ai == int'(END_A)) ? int'(START_A) : ai + 1;
    else     ai = (ai == int'(START_A)) ? int'(END_A) : ai - 1;
    return ADDR_W'(ai);
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? 32'(acc_log[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] samp_at(input int i);
    return (i < samp_log.size()) ? 32'(samp_log[i]) : 32'hxxxx_xxxx;
  endfunction

  task automatic cyc(input bit tk, input bit rs);
    bit          step_ev;
    int          npulse;
    logic [31:0] rd;
    step_ev = 0;
    @(negedge clk);
    if (p_reset) begin
      exp_addr = START_A; rst_flag = 0; sq.delete(); word_samples = 0; last_audio = '0;
      if (resp_pending) resp_stray = 1;
    end
    if (o_read && !p_wr) begin
      resp_pending = 1;
      resp_stray   = p_reset;
      lat_cnt      = $urandom_range(lat_max, lat_min);
      resp_data    = use_fixed ? fixed_data : $urandom;
      if (!p_reset) begin
        check("rd_addr", 32'(o_addr), 32'(exp_addr));
        check("byteenable", 32'(flash_mem_byteenable), 32'hF);
        check("rd_drop", 32'(flash_mem_read), 32'd0);
        acc_log.push_back(o_addr);
      end
    end
    if (!p_reset) begin
      npulse = int'(audio_valid) + int'(underrun);
      if (p_tick && p_play && o_busy) check("tick_outcome", npulse, 1);
      else                            check("no_pulse", npulse, 0);
      if (audio_valid) begin
        check("sample_owed", 32'(sq.size() > 0), 32'd1);
        if (sq.size() > 0) check("sample", 32'(audio_out), 32'(sq.pop_front()));
        samp_log.push_back(audio_out);
        last_audio = audio_out;
        word_samples++;
        if (word_samples == 2) begin
          word_samples = 0;
          step_ev = 1;
        end
      end
      if (underrun) begin
        under_cnt++;
        check("held", 32'(audio_out), 32'(last_audio));
      end
      if (p_rvalid && !p_stray) begin
        rd = flash_mem_readdata;
        if (p_dir) begin sq.push_back(rd[15:0]);  sq.push_back(rd[31:16]); end
        else       begin sq.push_back(rd[31:16]); sq.push_back(rd[15:0]);  end
      end
    end

    if (flash_mem_read) begin
      if (!in_req) begin
        in_req   = 1;
        wait_cnt = $urandom_range(wait_max, wait_min);
      end
      flash_mem_waitrequest = (wait_cnt > 0);
      if (wait_cnt > 0) wait_cnt--;
    end else begin
      in_req = 0;
      flash_mem_waitrequest = 1'b0;
    end
    if (resp_pending && lat_cnt == 0) begin
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata      = resp_data;
      drv_stray               = resp_stray;
      resp_pending            = 0;
    end else begin
      flash_mem_readdatavalid = 1'b0;
      if (resp_pending) lat_cnt--;
    end

    reset = drv_reset; play = drv_play; dir = drv_dir; sample_tick = tk; restart = rs;
    if (rs && !drv_reset) begin
      if (!busy) exp_addr = drv_dir ? START_A : END_A;
      else       rst_flag = 1;
    end
    if (step_ev && !drv_reset) begin
      exp_addr = rst_flag ? (drv_dir ? START_A : END_A) : next_addr(exp_addr, drv_dir);
      rst_flag = 0;
    end

    p_reset = drv_reset; p_tick = tk; p_play = drv_play; p_dir = drv_dir;
    p_wr = flash_mem_waitrequest; p_rvalid = flash_mem_readdatavalid; p_stray = drv_stray;
    o_read = flash_mem_read; o_busy = busy; o_addr = flash_mem_address;
  endtask

  task automatic wait_for(input int n_acc, input int n_samp, input int tick_pct, input int budget);
    int k;
    k = 0;
    while ((acc_log.size() < n_acc || samp_log.size() < n_samp) && k < budget) begin
      cyc(int'($urandom_range(99, 0)) < tick_pct, 0);
      k++;
    end
    check("progress", 32'(acc_log.size() >= n_acc && samp_log.size() >= n_samp), 32'd1);
  endtask

  task automatic do_reset(input bit dirv);
    drv_reset = 1; drv_play = 0; drv_dir = dirv;
    repeat (3) cyc(0, 0);
    drv_reset = 0;
    repeat (10) cyc(0, 0);
    acc_log.delete(); samp_log.delete(); under_cnt = 0;
  endtask

  task automatic set_flash(input int wmin, input int wmax, input int lmin, input int lmax);
    wait_min = wmin; wait_max = wmax; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    reset = 1'b1; sample_tick = 1'b0; play = 1'b0; dir = 1'b1; restart = 1'b0;
    flash_mem_waitrequest = 1'b0; flash_mem_readdata = '0; flash_mem_readdatavalid = 1'b0;

    // Reset state
    drv_reset = 1;
    repeat (3) cyc(0, 0);
    check("rst_read", 32'(flash_mem_read), 0);
    check("rst_addr", 32'(flash_mem_address), 32'(START_A));
    check("rst_audio", 32'(audio_out), 0);
    check("rst_valid", 32'(audio_valid), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_be", 32'(flash_mem_byteenable), 32'hF);

    // Forward basic
    do_reset(1);
    set_flash(2, 2, 3, 3); use_fixed = 1; fixed_data = 32'hBBBB_AAAA;
    drv_play = 1;
    wait_for(2, 2, 50, 500);
    check("fwd_s0", samp_at(0), 32'hAAAA);
    check("fwd_s1", samp_at(1), 32'hBBBB);
    check("fwd_a0", acc_at(0), 0);
    check("fwd_a1", acc_at(1), 1);

    // Backward wrap
    do_reset(0);
    fixed_data = 32'h2222_1111;
    drv_play = 1;
    wait_for(2, 2, 50, 500);
    check("bwd_s0", samp_at(0), 32'h2222);
    check("bwd_s1", samp_at(1), 32'h1111);
    check("bwd_a1", acc_at(1), 7);

    // Forward wrap from END_A after an IDLE restart
    do_reset(0);
    use_fixed = 0; set_flash(0, 3, 0, 4);
    cyc(0, 1);
    cyc(0, 0);
    check("restart_idle", 32'(flash_mem_address), 32'(END_A));
    drv_dir = 1; drv_play = 1;
    wait_for(2, 4, 50, 500);
    check("wrap_a0", acc_at(0), 7);
    check("wrap_a1", acc_at(1), 0);

    // Single tick while waiting for data
    do_reset(1);
    set_flash(1, 1, 4, 4);
    drv_play = 1;
    wait_for(1, 0, 0, 100);
    cyc(1, 0);
    cyc(0, 0);
    check("underrun_pulse", 32'(underrun), 1);
    check("underrun_valid", 32'(audio_valid), 0);
    check("underrun_count", under_cnt, 1);
    wait_for(1, 2, 50, 500);

    // Pause in PLAY1
    do_reset(1);
    set_flash(0, 2, 0, 3); use_fixed = 1; fixed_data = 32'hBBBB_AAAA;
    drv_play = 1;
    k = 0;
    while (samp_log.size() < 1 && k < 300) begin
      cyc(k % 2 == 0, 0);
      k++;
    end
    drv_play = 0;
    repeat (10) cyc(1, 0);
    check("pause_samples", samp_log.size(), 1);
    drv_play = 1;
    cyc(1, 0);
    cyc(0, 0);
    check("resume_valid", 32'(audio_valid), 1);
    check("resume_sample", 32'(audio_out), 32'hBBBB);
    wait_for(2, 2, 50, 500);
    check("resume_a1", acc_at(1), 1);

    // Restart while waiting for data at address 5
    do_reset(1);
    use_fixed = 0; set_flash(0, 2, 3, 3);
    drv_play = 1;
    wait_for(6, 10, 60, 2000);
    check("rs_a5", acc_at(5), 5);
    cyc(0, 1);
    wait_for(7, 12, 60, 500);
    check("rs_a6", acc_at(6), 32'(START_A));

    // Reset during REQ while playing
    set_flash(3, 3, 3, 3);
    k = 0;
    while (!(flash_mem_read && busy) && k < 200) begin
      cyc(int'($urandom_range(99, 0)) < 40, 0);
      k++;
    end
    check("req_seen", 32'(flash_mem_read), 1);
    drv_reset = 1;
    cyc(0, 0);
    drv_reset = 0;
    cyc(0, 0);
    check("rreq_read", 32'(flash_mem_read), 0);
    check("rreq_busy", 32'(busy), 0);
    check("rreq_audio", 32'(audio_out), 0);
    check("rreq_addr", 32'(flash_mem_address), 32'(START_A));

    // Reset while waiting for data; the late readdatavalid must be ignored
    base = acc_log.size();
    set_flash(0, 1, 3, 3);
    drv_play = 1;
    wait_for(base + 1, 0, 0, 100);
    drv_reset = 1; drv_play = 0;
    cyc(0, 0);
    drv_reset = 0;
    base = samp_log.size();
    repeat (10) cyc(1, 0);
    check("stray_samples", samp_log.size() - base, 0);
    drv_play = 1;
    wait_for(0, base + 2, 50, 500);

    // Random run
    do_reset(1);
    set_flash(0, 3, 0, 4); use_fixed = 0;
    drv_play = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 2) drv_dir = ~drv_dir;
      if (drv_play && $urandom_range(99, 0) < 2)       drv_play = 0;
      else if (!drv_play && $urandom_range(99, 0) < 20) drv_play = 1;
      cyc(int'($urandom_range(99, 0)) < 35, $urandom_range(99, 0) < 1);
    end
    check("random_progress", 32'(samp_log.size() >= 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_audio_sequencer.md
Name: flash_audio_sequencer

Overview:
- Sequences the Avalon-MM flash controller to stream 16-bit audio samples out of flash.
- Issues one 32-bit word read per two samples and splits each word into two samples.
- Steps the word address forward or backward and wraps at range limits.
- Paces sample delivery to the audio path with a one-cycle sample-rate strobe from the existing clock divider.

Parameters:
- ADDR_W, 23: width of the flash word address.
- START_ADDR, 23'h000000: first word address of the playback range.
- END_ADDR, 23'h07FFFF: last word address of the playback range, inclusive; must be >= START_ADDR.

Ports:
- clk  in  1  system clock (50 MHz); all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  single-cycle strobe at the audio sample rate.
- play  in  1  1 = run, 0 = pause.
- dir  in  1  1 = forward (increasing address), 0 = backward.
- restart  in  1  single-cycle request to jump to the start of playback.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  tied to 4'hF.
- flash_mem_waitrequest  in  1  Avalon waitrequest.
- flash_mem_readdata  in  32  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon read data valid.
- audio_out  out  16  current sample, signed, held between updates.
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- underrun  out  1  one-cycle pulse when a sample_tick is dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: sync, active-high, overrides everything.
  - flash_mem_read=0, flash_mem_address=START_ADDR, audio_out=0, audio_valid=0, underrun=0, busy=0.
  - State=IDLE, captured word=0, restart_pending=0.
- States: IDLE, REQ, WAIT_DATA, PLAY0, PLAY1, STEP.
- IDLE:
  - play=1 -> REQ.
  - A stray readdatavalid in IDLE is ignored.
- REQ:
  - flash_mem_read=1 with flash_mem_address stable.
  - Exit to WAIT_DATA on the first clk edge where flash_mem_waitrequest=0; read drops in that transition.
  - Read stays asserted regardless of play; an Avalon request is never aborted.
- WAIT_DATA:
  - On readdatavalid=1, capture readdata into a 32-bit word register -> PLAY0.
  - Transaction completes regardless of play.
- PLAY0 / PLAY1 (sample order):
  - dir=1: lower half [15:0] first, then upper half [31:16].
  - dir=0: upper half first, then lower half.
  - dir is latched at capture time for the word.
- PLAY0 / PLAY1 (timing):
  - On sample_tick=1 with play=1: audio_out gets the selected half, audio_valid pulses, and the FSM advances (PLAY0 -> PLAY1 -> STEP).
  - The audio_out update and audio_valid pulse are visible in the cycle after the tick edge.
  - With play=0, the FSM holds; ticks are ignored, audio_out is held, and underrun does not pulse.
- STEP (one cycle):
  - restart_pending=1: address = START_ADDR if dir=1, else END_ADDR; clear restart_pending.
  - Otherwise dir=1: address+1, wrapping END_ADDR -> START_ADDR.
  - Otherwise dir=0: address-1, wrapping START_ADDR -> END_ADDR.
  - Then -> REQ if play=1, else -> IDLE.
- Restart:
  - In IDLE, applied immediately (address set per dir, same cycle).
  - In any other state, sets restart_pending, applied at the next STEP.
  - A restart arriving in the same cycle as STEP is applied in that STEP.
- Underrun: sample_tick=1 with play=1 while in REQ, WAIT_DATA or STEP -> tick dropped, underrun pulses one cycle, audio_out unchanged.
- Direction change: affects the next STEP and the next captured word; the word currently playing finishes in its latched order.
- Address arithmetic is ADDR_W bits; the wrap compare against END_ADDR/START_ADDR happens before increment/decrement, so the address never leaves the range.
- Reset mid-transaction: read=0 in the cycle after reset; the outstanding readdatavalid lands in IDLE and is discarded.

Decomposition:
- Shared package flash_audio_pkg:
  - state enum type (6 states, one-hot-free binary encoding);
  - FLASH_BYTEENABLE = 4'hF constant;
  - sample width constant SAMPLE_W = 16.
- One sub-module: flash_addr_stepper, holding the address register and implementing wrap, direction and restart load.

Test Plan:
- Forward basic: START_ADDR=0; flash returns 32'hBBBB_AAAA after 2 waitrequest cycles and 3 latency cycles; two ticks -> audio_out 16'hAAAA then 16'hBBBB; next read issued at address 1.
- Backward wrap: dir=0, address=START_ADDR=0, END_ADDR=7; word 32'h2222_1111 -> audio 16'h2222 then 16'h1111; next address 7.
- Forward wrap at END_ADDR=7 -> next address 0; byteenable is 4'hF on every read.
- Underrun: tick asserted during WAIT_DATA -> underrun pulses once, audio_out held, no audio_valid.
- Pause: play=0 in PLAY1 for 10 ticks -> no audio_valid; play=1 plus tick -> 16'hBBBB emitted, then STEP.
- Restart and reset:
  - restart pulse in WAIT_DATA with dir=1 at address 5 -> current word finishes, next read at START_ADDR.
  - reset asserted during REQ -> read=0 next cycle; a later readdatavalid produces no audio_valid.
